fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage plus IF/ID pipeline latch, directly upstream of the decode unit. It holds the PC and issues instruction-memory reads. It captures each returned word into the IF/ID latch, along with PC+4, so decode can consume it. It also handles downstream stalls with a one-entry skid buffer, applies branch/jump redirects with a flush, and stops fetching on halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word driven on ins while the latch is invalid or flushed

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
ihit  input  1  instruction memory returns imemload for the current imemaddr this cycle
imemload  input  32  instruction word from memory
imemREN  output  1  instruction read request
imemaddr  output  32  read address (equals pc)
stall  input  1  decode/hazard stall; IF/ID must hold
redirect  input  1  taken branch/jump/jr resolved downstream
redirect_pc  input  32  target PC for redirect
halt  input  1  decode flags the IF/ID instruction as halt
pc  output  32  current fetch PC
ins  output  32  IF/ID instruction to decode
npc  output  32  IF/ID PC+4 of that instruction
ins_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (RST=1 at edge) sets:
  - pc=PC_INIT, ins=NOP_WORD, npc=0, ins_valid=0
  - skid buffer empty, state=FETCH
  - Reset has priority over every other input and aborts any pending read.
- States:
  - FETCH: normal operation.
  - HALTED: absorbing; exits only on reset.
- imemREN = (state==FETCH) && !skid_valid; imemaddr = pc. Both are combinational from registers.
- Fetch accept happens on ihit && imemREN && !redirect:
  - pc <= pc+4, with 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
  - If !stall: IF/ID <= {imemload, pc+4}, ins_valid <= 1.
  - If stall: skid <= {imemload, pc+4}, skid_valid <= 1. IF/ID holds.
- Skid drain happens when skid_valid && !stall && !redirect:
  - IF/ID <= skid, skid_valid <= 0.
  - No new request issues that cycle because imemREN=0.
- With !stall, no accept and no skid: ins_valid <= 0 and ins <= NOP_WORD, a bubble while waiting for ihit.
- With stall: IF/ID holds its value regardless of ihit.
- Redirect (highest priority after reset):
  - pc <= redirect_pc.
  - IF/ID flushed: ins=NOP_WORD, ins_valid=0.
  - skid cleared.
  - Any ihit in the same cycle is discarded.
  - Overrides stall.
- Halt: when halt && ins_valid && !redirect, state <= HALTED.
  - In HALTED: pc frozen, imemREN=0, IF/ID holds the halt instruction, ins_valid stays 1.
- Halt and redirect in the same cycle: redirect wins, because the older instruction redirected; state stays FETCH.
- Latency: word returned with ihit at cycle N appears on ins/ins_valid at cycle N+1 when not stalled.
- Throughput: one instruction per cycle when ihit stays high.

Test Plan:
- Reset → pc=0, ins_valid=0, imemREN=1. Then ihit=1 every cycle with imemload=0x2001_0005, 0x2002_0007 → ins sequence 0x20010005 (npc=4), 0x20020007 (npc=8); pc=8.
- Miss latency: hold ihit=0 for 3 cycles at pc=0x40 → 3 bubble cycles (ins=0, ins_valid=0), pc stays 0x40. Then ihit → ins valid, npc=0x44.
- Stall with skid:
  - stall=1 while ihit returns 0xAAAA_AAAA → IF/ID unchanged, skid full, imemREN=0, pc advanced by 4.
  - Deassert stall → ins=0xAAAAAAAA next cycle, then the request resumes.
- Redirect during stall with full skid, redirect_pc=0x100, ihit=1 same cycle → pc=0x100, ins_valid=0, skid empty. Next fetch is at imemaddr=0x100.
- Halt: halt=1 with ins_valid=1 → imemREN=0 forever and pc frozen. Halt and redirect together → pc=redirect_pc and fetching continues.
- Wrap and reset mid-miss:
  - pc=0xFFFF_FFFC with ihit → pc=0.
  - RST asserted during a pending miss → pc=PC_INIT and ins_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with the IF/ID pipeline latch. Holds the fetch PC,
//   issues instruction-memory reads, and captures each returned word together
//   with its PC+4 for the decode stage. A one-entry skid buffer absorbs a word
//   that returns while decode is stalled. Redirects flush the latch and skid,
//   and a decoded halt freezes the stage until reset.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   RST          synchronous active-high reset
//   ihit         memory returns imemload for imemaddr this cycle
//   imemload     instruction word from memory
//   imemREN      read request (combinational from registers)
//   imemaddr     read address, always equal to pc
//   stall        decode/hazard stall; IF/ID holds
//   redirect     taken branch/jump resolved downstream
//   redirect_pc  target PC for redirect
//   halt         decode flags the IF/ID instruction as halt
//   pc           current fetch PC
//   ins          IF/ID instruction word
//   npc          IF/ID PC+4 of that instruction
//   ins_valid    IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic [31:0] npc,
  output logic        ins_valid
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t      state, state_next;

  // Skid buffer: holds one returned word while IF/ID is stalled.
  logic        skid_valid, skid_valid_next;
  logic [31:0] skid_ins, skid_ins_next;
  logic [31:0] skid_npc, skid_npc_next;

  logic [31:0] pc_next;
  logic [31:0] ins_next;
  logic [31:0] npc_next;
  logic        ins_valid_next;

  logic [31:0] pc_plus4;
  logic        accept;

  // No request while the skid is occupied: the drain cycle uses the latch
  // write port, so a second word would have nowhere to go.
  assign imemREN  = (state == FETCH) && !skid_valid;
  assign imemaddr = pc;
  assign pc_plus4 = pc + 32'd4;
  assign accept   = ihit && imemREN;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ins_next        = ins;
    npc_next        = npc;
    ins_valid_next  = ins_valid;
    skid_valid_next = skid_valid;
    skid_ins_next   = skid_ins;
    skid_npc_next   = skid_npc;

    unique case (state)
      FETCH: begin
        if (redirect) begin
          // Redirect beats stall and halt; any word returning now is stale.
          pc_next         = redirect_pc;
          ins_next        = NOP_WORD;
          ins_valid_next  = 1'b0;
          skid_valid_next = 1'b0;
        end else if (halt && ins_valid) begin
          // Freeze on the halt instruction: the latch keeps it and no
          // further fetch is accepted.
          state_next = HALTED;
        end else begin
          if (accept) begin
            pc_next = pc_plus4;
          end
          if (stall) begin
            if (accept) begin
              skid_valid_next = 1'b1;
              skid_ins_next   = imemload;
              skid_npc_next   = pc_plus4;
            end
          end else if (skid_valid) begin
            ins_next        = skid_ins;
            npc_next        = skid_npc;
            ins_valid_next  = 1'b1;
            skid_valid_next = 1'b0;
          end else if (accept) begin
            ins_next       = imemload;
            npc_next       = pc_plus4;
            ins_valid_next = 1'b1;
          end else begin
            // Waiting on memory: hand decode a bubble.
            ins_next       = NOP_WORD;
            ins_valid_next = 1'b0;
          end
        end
      end
      HALTED: begin
        // Absorbing; only reset leaves this state.
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      ins        <= NOP_WORD;
      npc        <= '0;
      ins_valid  <= 1'b0;
      skid_valid <= 1'b0;
      skid_ins   <= '0;
      skid_npc   <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ins        <= ins_next;
      npc        <= npc_next;
      ins_valid  <= ins_valid_next;
      skid_valid <= skid_valid_next;
      skid_ins   <= skid_ins_next;
      skid_npc   <= skid_npc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT  = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect, halt;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, ins_valid;
  logic [31:0] imemaddr, pc, ins, npc;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.PC_INIT(PC_INIT), .NOP_WORD(NOP_WORD)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .pc(pc), .ins(ins), .npc(npc), .ins_valid(ins_valid)
  );

  always #5 CLK = ~CLK;

  // Reference model: a program-order view of the stage.
  logic [31:0] m_pc, m_ins, m_npc;
  logic        m_valid, m_halted;
  logic [63:0] m_skid[$];

  function automatic logic [97:0] model_vec();
    logic req;
    req = !m_halted && (m_skid.size() == 0);
    return {m_pc, m_ins, m_npc, m_valid, req};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {pc, ins, npc, ins_valid, imemREN};
  endfunction

  // Evaluate the model on the inputs now applied, then clock the DUT.
  task automatic tick();
    logic        got;
    logic [31:0] addr;
    logic [63:0] w;
    if (RST) begin
      m_pc = PC_INIT; m_ins = NOP_WORD; m_npc = '0; m_valid = 1'b0;
      m_halted = 1'b0; m_skid.delete();
    end else if (m_halted) begin
      // frozen
    end else if (redirect) begin
      m_pc = redirect_pc; m_ins = NOP_WORD; m_valid = 1'b0; m_skid.delete();
    end else if (halt && m_valid) begin
      m_halted = 1'b1;
    end else begin
      addr = m_pc;
      got  = ihit && (m_skid.size() == 0);
      if (got) m_pc = m_pc + 32'd4;
      if (stall) begin
        if (got) m_skid.push_back({imemload, addr + 32'd4});
      end else if (m_skid.size() != 0) begin
        w = m_skid.pop_front();
        m_ins = w[63:32]; m_npc = w[31:0]; m_valid = 1'b1;
      end else if (got) begin
        m_ins = imemload; m_npc = addr + 32'd4; m_valid = 1'b1;
      end else begin
        m_ins = NOP_WORD; m_valid = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    imemload = '0; redirect_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
    tick();
    RST = 1'b0; ihit = 1'b0;
    checks++;
    if ({pc, ins, npc, ins_valid, imemREN} !== {PC_INIT, NOP_WORD, 32'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset: pc=%h ins=%h npc=%h v=%b ren=%b required pc=%h ins=%h npc=0 v=0 ren=1",
               pc, ins, npc, ins_valid, imemREN, PC_INIT, NOP_WORD);
    end
  endtask

  task automatic test_basic();
    ihit = 1'b1; imemload = 32'h2001_0005;
    tick();
    checks++;
    if ({ins, npc, ins_valid} !== {32'h2001_0005, 32'd4, 1'b1}) begin
      failures++;
      $display("FAIL basic_first: ins=%h npc=%h v=%b required ins=20010005 npc=4 v=1", ins, npc, ins_valid);
    end
    imemload = 32'h2002_0007;
    tick();
    ihit = 1'b0;
    checks++;
    if ({ins, npc, pc} !== {32'h2002_0007, 32'd8, 32'd8}) begin
      failures++;
      $display("FAIL basic_second: ins=%h npc=%h pc=%h required 20020007/8/8", ins, npc, pc);
    end
  endtask

  task automatic test_miss();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pc, ins, ins_valid, imemREN} !== {32'h40, NOP_WORD, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL miss_bubble%0d: pc=%h ins=%h v=%b ren=%b required pc=40 ins=0 v=0 ren=1",
                 i, pc, ins, ins_valid, imemREN);
      end
    end
    ihit = 1'b1; imemload = 32'h1234_5678;
    tick();
    ihit = 1'b0;
    checks++;
    if ({ins, npc, ins_valid, pc} !== {32'h1234_5678, 32'h44, 1'b1, 32'h44}) begin
      failures++;
      $display("FAIL miss_return: ins=%h npc=%h v=%b pc=%h required 12345678/44/1/44", ins, npc, ins_valid, pc);
    end
  endtask

  task automatic test_skid();
    logic [31:0] old_ins, old_npc, old_pc;
    old_ins = ins; old_npc = npc; old_pc = pc;
    stall = 1'b1; ihit = 1'b1; imemload = 32'hAAAA_AAAA;
    tick();
    checks++;
    if ({ins, npc, imemREN, pc} !== {old_ins, old_npc, 1'b0, old_pc + 32'd4}) begin
      failures++;
      $display("FAIL skid_fill: ins=%h npc=%h ren=%b pc=%h required %h/%h/0/%h",
               ins, npc, imemREN, pc, old_ins, old_npc, old_pc + 32'd4);
    end
    stall = 1'b0; ihit = 1'b1; imemload = 32'h5555_5555;
    tick();
    ihit = 1'b0;
    checks++;
    if ({ins, npc, ins_valid, imemREN, pc} !== {32'hAAAA_AAAA, old_pc + 32'd4, 1'b1, 1'b1, old_pc + 32'd4}) begin
      failures++;
      $display("FAIL skid_drain: ins=%h npc=%h v=%b ren=%b pc=%h required aaaaaaaa/%h/1/1/%h",
               ins, npc, ins_valid, imemREN, pc, old_pc + 32'd4, old_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; ihit = 1'b1; imemload = 32'hBBBB_BBBB;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100; imemload = 32'hCCCC_CCCC;
    tick();
    redirect = 1'b0; ihit = 1'b0; stall = 1'b0;
    checks++;
    if ({pc, ins_valid, ins, imemREN, imemaddr} !== {32'h100, 1'b0, NOP_WORD, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL redirect_stall: pc=%h v=%b ins=%h ren=%b addr=%h required 100/0/0/1/100",
               pc, ins_valid, ins, imemREN, imemaddr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] hpc, hins;
    ihit = 1'b1; imemload = 32'hFC00_0000;
    tick();
    ihit = 1'b0; halt = 1'b1;
    hpc = pc; hins = ins;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ihit = 1'b1; stall = i[0]; imemload = $urandom;
      tick();
      checks++;
      if ({imemREN, pc, ins, ins_valid} !== {1'b0, hpc, hins, 1'b1}) begin
        failures++;
        $display("FAIL halted%0d: ren=%b pc=%h ins=%h v=%b required 0/%h/%h/1",
                 i, imemREN, pc, ins, ins_valid, hpc, hins);
      end
    end
    idle_inputs(); RST = 1'b1;
    tick();
    RST = 1'b0;
    ihit = 1'b1; imemload = 32'hFC00_0000;
    tick();
    ihit = 1'b0; halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    halt = 1'b0; redirect = 1'b0;
    checks++;
    if ({pc, imemREN, ins_valid} !== {32'h200, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL halt_redirect: pc=%h ren=%b v=%b required 200/1/0", pc, imemREN, ins_valid);
    end
    ihit = 1'b1; imemload = 32'h0000_1111;
    tick();
    ihit = 1'b0;
    checks++;
    if ({pc, ins, npc, ins_valid} !== {32'h204, 32'h0000_1111, 32'h204, 1'b1}) begin
      failures++;
      $display("FAIL halt_redirect_fetch: pc=%h ins=%h npc=%h v=%b required 204/1111/204/1",
               pc, ins, npc, ins_valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; ihit = 1'b1; imemload = 32'h7777_0000;
    tick();
    ihit = 1'b0;
    checks++;
    if ({pc, npc, ins} !== {32'd0, 32'd0, 32'h7777_0000}) begin
      failures++;
      $display("FAIL wrap: pc=%h npc=%h ins=%h required 0/0/77770000", pc, npc, ins);
    end
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    RST = 1'b1; ihit = 1'b1; imemload = 32'h9999_9999;
    tick();
    RST = 1'b0; ihit = 1'b0;
    checks++;
    if ({pc, ins_valid, ins} !== {PC_INIT, 1'b0, NOP_WORD}) begin
      failures++;
      $display("FAIL reset_mid_miss: pc=%h v=%b ins=%h required %h/0/%h", pc, ins_valid, ins, PC_INIT, NOP_WORD);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      RST         = ($urandom_range(0, 99) < 2);
      ihit        = $urandom_range(0, 3) != 0;
      stall       = $urandom_range(0, 3) == 0;
      redirect    = $urandom_range(0, 15) == 0;
      halt        = $urandom_range(0, 31) == 0;
      imemload    = $urandom;
      redirect_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (halt) ihit = 1'b0;
      if (i % 60 == 59) RST = 1'b1;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random%0d: pc/ins/npc/v/ren=%h required %h", i, dut_vec(), model_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = PC_INIT; m_ins = NOP_WORD; m_npc = '0; m_valid = 1'b0; m_halted = 1'b0;
    test_reset();
    test_basic();
    test_miss();
    test_skid();
    test_redirect_stall();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
